truth_table_sweeper: RTL and testbench

//  Sequencer for the 4-input combinational function block (inputs pp,qq,rr,ss; output tt).
//  On start, steps the block through all 16 pqrs vectors in ascending order (pqrs = 0000..1111).

---
 rtl/truth_table_sweeper_if.sv | 29 ++
 rtl/truth_table_sweeper.sv | 103 ++++++++++
 tb/tb_truth_table_sweeper.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
// Bus between the truth-table sweeper and its environment: control handshake,
// the pqrs/tt link to the function block, results and an FSM debug view.
interface truth_table_sweeper_if;
    // start is a one-cycle request, accepted only while busy==0 and done==0;
    // busy stays high until the sweep ends, and done pulses for exactly one cycle.
    logic        start;
    logic        tt;
    logic        pp;
    logic        qq;
    logic        rr;
    logic        ss;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] captured;
    logic [4:0]  err_count;
    logic [3:0]  first_err;
    logic [1:0]  state_dbg;

    modport master (
        input  start, tt,
        output pp, qq, rr, ss, busy, done, pass, captured, err_count, first_err, state_dbg
    );

    modport slave (
        output start, tt,
        input  pp, qq, rr, ss, busy, done, pass, captured, err_count, first_err, state_dbg
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Steps a 4-input function block through pqrs = 0..15 and checks tt against EXPECTED.
// Optional macro SWEEP_STOP_ON_ERR_EN: end the sweep at the first mismatching vector.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [15:0] EXPECTED      = 16'h4644
) (
    input  logic                  clk,
    input  logic                  reset,
    truth_table_sweeper_if.master sw
);
    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, FIN} state_t;

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic [7:0]  cnt;
    logic [15:0] captured;
    logic [4:0]  err_count;
    logic [3:0]  first_err;
    logic        pass;
    logic        mismatch;

    assign mismatch = (sw.tt != EXPECTED[idx]);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (sw.start) state_nxt = APPLY;
            APPLY:  if (cnt == 8'd0) state_nxt = SAMPLE;
            SAMPLE: begin
`ifdef SWEEP_STOP_ON_ERR_EN
                if (mismatch || idx == 4'd15) state_nxt = FIN;
                else                          state_nxt = APPLY;
`else
                if (idx == 4'd15) state_nxt = FIN;
                else              state_nxt = APPLY;
`endif
            end
            FIN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // idx doubles as the registered pqrs vector; it returns to 0 in FIN and on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= 4'd0;
            cnt       <= 8'd0;
            captured  <= 16'd0;
            err_count <= 5'd0;
            first_err <= 4'd0;
            pass      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sw.start) begin
                        idx       <= 4'd0;
                        cnt       <= CNT_LOAD;
                        captured  <= 16'd0;
                        err_count <= 5'd0;
                        first_err <= 4'd0;
                        pass      <= 1'b0;
                    end
                end
                APPLY: begin
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                end
                SAMPLE: begin
                    captured[idx] <= sw.tt;
                    if (mismatch) begin
                        err_count <= err_count + 5'd1;
                        if (err_count == 5'd0) first_err <= idx;
                    end
                    if (state_nxt == APPLY) begin
                        idx <= idx + 4'd1;
                        cnt <= CNT_LOAD;
                    end
                end
                FIN: begin
                    pass <= (err_count == 5'd0);
                    idx  <= 4'd0;
                end
                default: ;
            endcase
        end
    end

    assign {sw.pp, sw.qq, sw.rr, sw.ss} = idx;
    assign sw.busy      = (state == APPLY) || (state == SAMPLE);
    assign sw.done      = (state == FIN);
    assign sw.pass      = pass;
    assign sw.captured  = captured;
    assign sw.err_count = err_count;
    assign sw.first_err = first_err;
    assign sw.state_dbg = state;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: golden and stuck-at function blocks,
// ignored restarts, back-to-back sweeps, mid-sweep reset and a fast-settle instance.
module tb_truth_table_sweeper;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  truth_table_sweeper_if a_if ();
  truth_table_sweeper_if b_if ();

  truth_table_sweeper #(.SETTLE_CYCLES(4), .EXPECTED(16'h4644)) dut_a (
    .clk(clk), .reset(reset), .sw(a_if.master));
  truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(16'h4644)) dut_b (
    .clk(clk), .reset(reset), .sw(b_if.master));

  // Function block under control: 0 = golden, 1 = stuck-at-0, 2 = stuck-at-1.
  int tt_mode = 0;

  function automatic logic fblock(input int mode, input logic [3:0] v);
    logic p, q, r, s;
    {p, q, r, s} = v;
    if (mode == 1) return 1'b0;
    if (mode == 2) return 1'b1;
    return (r & ~s) | (p & ~q & ~r & s);
  endfunction

  always_comb a_if.tt = fblock(tt_mode, {a_if.pp, a_if.qq, a_if.rr, a_if.ss});
  always_comb b_if.tt = fblock(0, {b_if.pp, b_if.qq, b_if.rr, b_if.ss});

  // Observed view of whichever instance is selected.
  int          sel = 0;
  logic        o_done, o_busy, o_pass;
  logic [15:0] o_cap;
  logic [4:0]  o_err;
  logic [3:0]  o_first, o_vec;
  always_comb begin
    o_done  = a_if.done;
    o_busy  = a_if.busy;
    o_pass  = a_if.pass;
    o_cap   = a_if.captured;
    o_err   = a_if.err_count;
    o_first = a_if.first_err;
    o_vec   = {a_if.pp, a_if.qq, a_if.rr, a_if.ss};
    if (sel == 1) begin
      o_done  = b_if.done;
      o_busy  = b_if.busy;
      o_pass  = b_if.pass;
      o_cap   = b_if.captured;
      o_err   = b_if.err_count;
      o_first = b_if.first_err;
      o_vec   = {b_if.pp, b_if.qq, b_if.rr, b_if.ss};
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;
  int t0       = 0;

  // Scoreboard entry: {latency[15:0], captured[15:0], err_count[4:0], first_err[3:0]}
  logic [40:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel == 1) b_if.start = v;
    else          a_if.start = v;
  endtask

  task automatic push_expected(input int mode, input int settle);
    logic [15:0] golden;
    logic [15:0] cap;
    logic [3:0]  v;
    logic        g;
    int          errs, fe, last, lat;
    golden = 16'h4644;
    cap = 16'd0;
    errs = 0;
    fe = 0;
    last = 15;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      g = fblock(mode, v);
      cap[i] = g;
      if (g != golden[i]) begin
        if (errs == 0) fe = i;
        errs++;
`ifdef SWEEP_STOP_ON_ERR_EN
        last = i;
        break;
`endif
      end
    end
    lat = (last + 1) * (settle + 1) + 1;
    exp_q.push_back({16'(lat), cap, 5'(errs), 4'(fe)});
  endtask

  // Called at a negedge; start is high for this cycle (cycle 0 of the sweep).
  task automatic drive_start();
    set_start(1'b1);
    t0 = cyc;
    @(negedge clk);
    set_start(1'b0);
  endtask

  task automatic wait_cycle(input int n);
    while ((cyc - t0) < n) @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int restart_at, input int budget);
    logic [40:0] e;
    bit          seen;
    seen = 0;
    for (int k = 0; k < budget; k++) begin
      set_start((cyc - t0) == restart_at);
      if (o_done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    set_start(1'b0);
    if (!seen) begin
      check({tag, "_done_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_done"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_latency"},   32'(cyc - t0), 32'(e[40:25]));
    check({tag, "_captured"},  32'(o_cap),    32'(e[24:9]));
    check({tag, "_err_count"}, 32'(o_err),    32'(e[8:4]));
    if (e[8:4] != 5'd0) check({tag, "_first_err"}, 32'(o_first), 32'(e[3:0]));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(o_done), 32'd0);
    check({tag, "_busy_after"}, 32'(o_busy), 32'd0);
    check({tag, "_pass"},       32'(o_pass), 32'(e[8:4] == 5'd0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_vec"},      32'(o_vec),   32'd0);
    check({tag, "_busy"},     32'(o_busy),  32'd0);
    check({tag, "_done"},     32'(o_done),  32'd0);
    check({tag, "_pass"},     32'(o_pass),  32'd0);
    check({tag, "_captured"}, 32'(o_cap),   32'd0);
    check({tag, "_err"},      32'(o_err),   32'd0);
    check({tag, "_first"},    32'(o_first), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    reset = 1'b1;
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset_a");
    reset = 1'b0;
    @(negedge clk);

    // Golden sweep with a live mid-sweep look.
    tt_mode = 0;
    push_expected(0, 4);
    drive_start();
    wait_cycle(7);
    check("golden_mid_vec",  32'(o_vec),  32'd1);
    check("golden_mid_busy", 32'(o_busy), 32'd1);
    wait_done("golden", -1, 200);

    tt_mode = 1;
    push_expected(1, 4);
    drive_start();
    wait_done("stuck0", -1, 200);

    tt_mode = 2;
    push_expected(2, 4);
    drive_start();
    wait_done("stuck1", -1, 200);

    // Restart pulse at cycle 30 must be ignored, then a back-to-back start.
    tt_mode = 0;
    push_expected(0, 4);
    drive_start();
    wait_done("restart_ignored", 30, 200);
    push_expected(0, 4);
    drive_start();
    check("b2b_pass_cleared", 32'(o_pass), 32'd0);
    check("b2b_busy",         32'(o_busy), 32'd1);
    wait_done("b2b", -1, 200);

    // Reset in the middle of a sweep abandons it.
    push_expected(0, 4);
    drive_start();
    wait_cycle(40);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("midreset");
    void'(exp_q.pop_back());
    ndone = 0;
    for (int k = 0; k < 100; k++) begin
      if (o_done) ndone++;
      @(negedge clk);
    end
    check("midreset_no_done", 32'(ndone), 32'd0);
    push_expected(0, 4);
    drive_start();
    wait_done("after_reset", -1, 200);

    // Fast-settle instance.
    sel = 1;
    push_expected(0, 1);
    drive_start();
    wait_cycle(3);
    check("settle1_mid_vec", 32'(o_vec), 32'd1);
    wait_done("settle1", -1, 100);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
